ra_2r1w_64x72_sdr_array: RTL and testbench
==========================================

Name: ra_2r1w_64x72_sdr_array

Overview:
- Single-data-rate register array with 64 words x 72 bits, two read ports and one write port (2R1W).
- Sits behind the BIST input mux and is timed by the local clock block (LCB) strobe.
- Inputs are captured on the clock edge. The storage access is then qualified by strobe on the next edge, and read data is delivered from output registers.

Parameters:
- None. Geometry is fixed at 64 words, 72-bit data, 6-bit address.

Ports:
- clk  in  1  array clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- strobe  in  1  LCB access strobe; storage access happens only when high.
- rd_enb_0  in  1  read enable, port 0.
- rd_adr_0  in  6  read address, port 0, bit 0 = MSB.
- rd_dat_0  out  72  read data, port 0, bit 0 = MSB.
- rd_enb_1  in  1  read enable, port 1.
- rd_adr_1  in  6  read address, port 1.
- rd_dat_1  out  72  read data, port 1.
- wr_enb_0  in  1  write enable.
- wr_adr_0  in  6  write address.
- wr_dat_0  in  72  write data.

Behaviour:
- Reset (reset=0, asynchronous):
  - All input-capture registers clear to 0.
  - rd_dat_0 and rd_dat_1 clear to 0.
  - Storage contents are not reset. Reading a word never written returns undefined data; software and BIST write before reading.
- Edge N (capture): rd_enb_x, rd_adr_x, wr_enb_0, wr_adr_0 and wr_dat_0 are registered unconditionally every cycle.
- Edge N+1 (access), only if strobe=1 at that edge:
  - If the captured wr_enb=1, mem[captured wr_adr] <= captured wr_dat.
  - For each read port with captured rd_enb=1, rd_dat_x <= mem[captured rd_adr].
- Read latency is 2 clocks: enable/address presented before edge N, data valid after edge N+1.
- Write becomes visible to a read captured at edge N+1 or later, i.e. visible 1 cycle after the write's access edge.
- Captured rd_enb=0 or strobe=0: rd_dat_x holds its previous value.
- Strobe=0 at the access edge: no write occurs and the captured operation is dropped, not retried.
- Read/write collision (same address, same access edge): the read returns the old contents (read-before-write). The new data is visible on the next access.
- Both read ports on the same address: both return identical data, with no conflict.
- Address wrap: all 64 addresses are valid; 6'h3F is the last word, with no out-of-range case.
- Reset asserted mid-operation:
  - Pending captured operations are discarded and outputs go to 0 immediately.
  - Storage written before reset keeps its value.

Decomposition:
- Shared package/header (toysram.vh style) holds:
  - RA_WORDS=64, RA_WIDTH=72, RA_ADRW=6.
  - The LCB config width constant, used by neighbouring blocks.
- One natural sub-module, ra_2r1w_64x72_mem: the bare storage.
  - Single clocked write port gated by an enable.
  - Two combinational read ports.
- The top holds the capture registers, the strobe qualification and the output registers.

Test Plan:
- Reset: hold reset=0 with random inputs -> rd_dat_0 = rd_dat_1 = 72'h0. Release, idle with enables=0 -> outputs stay 0.
- Basic write/read, strobe=1 always:
  - Write adr 6'h05 data 72'hA5_0123456789ABCDEF.
  - Two cycles later read port 0 adr 5 -> rd_dat_0 equals that data 2 edges after read-enable capture.
- Dual read:
  - Write adr 0 = 72'h0, adr 63 = 72'hFF_FFFFFFFFFFFFFFFF.
  - Port 0 reads 63 while port 1 reads 0 in the same cycle -> all-ones / all-zero respectively.
- Collision:
  - Mem[10] = 72'h11.
  - Same cycle: write adr 10 = 72'h22 and read adr 10 -> rd_dat_0 = 72'h11.
  - Next read -> 72'h22.
- Strobe gating:
  - Strobe=0 on the access edge of a write to adr 3 (previously 72'h33) plus a read -> mem[3] still 72'h33 and rd_dat holds its prior value.
  - Repeat with strobe=1 -> updated.
- Sweep:
  - Write address-dependent pattern {adr repeated} to all 64 words, read back on both ports -> every word matches.
  - Assert reset mid-sweep, then re-read -> earlier words intact and outputs 0 during reset.

Source files
------------

// File: rtl/ra_2r1w_64x72_sdr_array_pkg.sv
// Shared geometry and configuration constants for the 64x72 2R1W register array
// and the neighbouring LCB logic.
package ra_2r1w_64x72_sdr_array_pkg;

    localparam int RA_WORDS      = 64;
    localparam int RA_WIDTH      = 72;
    localparam int RA_ADRW       = 6;
    localparam int RA_RD_PORTS   = 2;

    // Width of the local clock block configuration word used by neighbouring blocks.
    localparam int LCB_CFG_WIDTH = 8;

endpackage

// File: rtl/ra_2r1w_64x72_mem.sv
// Bare 64x72 storage: one clocked, enable-gated write port and two combinational
// read ports. Contents are intentionally not reset.
module ra_2r1w_64x72_mem
    import ra_2r1w_64x72_sdr_array_pkg::*;
(
    input  logic                  clk,
    input  logic                  wr_enb,
    input  logic [0:RA_ADRW-1]    wr_adr,
    input  logic [0:RA_WIDTH-1]   wr_dat,
    input  logic [0:RA_ADRW-1]    rd_adr_0,
    output logic [0:RA_WIDTH-1]   rd_dat_0,
    input  logic [0:RA_ADRW-1]    rd_adr_1,
    output logic [0:RA_WIDTH-1]   rd_dat_1
);

    logic [0:RA_WIDTH-1] mem [RA_WORDS];

    always_ff @(posedge clk) begin
        if (wr_enb) begin
            mem[wr_adr] <= wr_dat;
        end
    end

    // Reads see the pre-edge contents, which gives read-before-write on a collision.
    assign rd_dat_0 = mem[rd_adr_0];
    assign rd_dat_1 = mem[rd_adr_1];

endmodule

// File: rtl/ra_2r1w_64x72_sdr_array.sv
// 64x72 2R1W single-data-rate register array: inputs captured on one edge,
// storage accessed on the next edge only when the LCB strobe is high.
module ra_2r1w_64x72_sdr_array
    import ra_2r1w_64x72_sdr_array_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  strobe,
    input  logic                  rd_enb_0,
    input  logic [0:RA_ADRW-1]    rd_adr_0,
    output logic [0:RA_WIDTH-1]   rd_dat_0,
    input  logic                  rd_enb_1,
    input  logic [0:RA_ADRW-1]    rd_adr_1,
    output logic [0:RA_WIDTH-1]   rd_dat_1,
    input  logic                  wr_enb_0,
    input  logic [0:RA_ADRW-1]    wr_adr_0,
    input  logic [0:RA_WIDTH-1]   wr_dat_0
);

    logic                  rd_enb_in   [RA_RD_PORTS];
    logic [0:RA_ADRW-1]    rd_adr_in   [RA_RD_PORTS];
    logic                  rd_enb_reg  [RA_RD_PORTS];
    logic [0:RA_ADRW-1]    rd_adr_reg  [RA_RD_PORTS];
    logic [0:RA_WIDTH-1]   rd_dat_reg  [RA_RD_PORTS];
    logic [0:RA_WIDTH-1]   mem_rd_dat  [RA_RD_PORTS];

    logic                  wr_enb_reg;
    logic [0:RA_ADRW-1]    wr_adr_reg;
    logic [0:RA_WIDTH-1]   wr_dat_reg;
    logic                  wr_access;

    assign rd_enb_in[0] = rd_enb_0;
    assign rd_enb_in[1] = rd_enb_1;
    assign rd_adr_in[0] = rd_adr_0;
    assign rd_adr_in[1] = rd_adr_1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_enb_reg <= 1'b0;
            wr_adr_reg <= '0;
            wr_dat_reg <= '0;
        end else begin
            wr_enb_reg <= wr_enb_0;
            wr_adr_reg <= wr_adr_0;
            wr_dat_reg <= wr_dat_0;
        end
    end

    // A captured write that meets a low strobe is simply lost; nothing is retried.
    assign wr_access = strobe & wr_enb_reg;

    genvar gi;
    generate
        for (gi = 0; gi < RA_RD_PORTS; gi++) begin : g_rd_port
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    rd_enb_reg[gi] <= 1'b0;
                    rd_adr_reg[gi] <= '0;
                end else begin
                    rd_enb_reg[gi] <= rd_enb_in[gi];
                    rd_adr_reg[gi] <= rd_adr_in[gi];
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    rd_dat_reg[gi] <= '0;
                end else if (strobe && rd_enb_reg[gi]) begin
                    rd_dat_reg[gi] <= mem_rd_dat[gi];
                end
            end
        end
    endgenerate

    ra_2r1w_64x72_mem u_mem (
        .clk      (clk),
        .wr_enb   (wr_access),
        .wr_adr   (wr_adr_reg),
        .wr_dat   (wr_dat_reg),
        .rd_adr_0 (rd_adr_reg[0]),
        .rd_dat_0 (mem_rd_dat[0]),
        .rd_adr_1 (rd_adr_reg[1]),
        .rd_dat_1 (mem_rd_dat[1])
    );

    assign rd_dat_0 = rd_dat_reg[0];
    assign rd_dat_1 = rd_dat_reg[1];

endmodule

// File: tb/tb_ra_2r1w_64x72_sdr_array.sv
// Scoreboard bench for the 64x72 2R1W array: the driver queues expected read data
// tagged with the cycle it must appear, and a negedge monitor checks it.
module tb_ra_2r1w_64x72_sdr_array;

    logic          clk = 1'b0;
    logic          reset;
    logic          strobe;
    logic          rd_enb_0, rd_enb_1, wr_enb_0;
    logic [0:5]    rd_adr_0, rd_adr_1, wr_adr_0;
    logic [0:71]   wr_dat_0;
    logic [0:71]   rd_dat_0, rd_dat_1;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    typedef struct {
        int          due;
        int          port;
        logic [71:0] data;
    } exp_t;

    exp_t sb[$];

    ra_2r1w_64x72_sdr_array dut (
        .clk      (clk),
        .reset    (reset),
        .strobe   (strobe),
        .rd_enb_0 (rd_enb_0),
        .rd_adr_0 (rd_adr_0),
        .rd_dat_0 (rd_dat_0),
        .rd_enb_1 (rd_enb_1),
        .rd_adr_1 (rd_adr_1),
        .rd_dat_1 (rd_dat_1),
        .wr_enb_0 (wr_enb_0),
        .wr_adr_0 (wr_adr_0),
        .wr_dat_0 (wr_dat_0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every expectation due this cycle is compared against the live output.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due <= cyc) begin
                logic [71:0] act;
                act = (sb[i].port == 1) ? rd_dat_1 : rd_dat_0;
                checks++;
                if (sb[i].due == cyc && act === sb[i].data) begin
                    passes++;
                    $display("check rd_dat_%0d cyc %0d ok: %h", sb[i].port, cyc, act);
                end else begin
                    $display("FAIL rd_dat_%0d cyc %0d: got %h expected %h (due %0d)",
                             sb[i].port, cyc, act, sb[i].data, sb[i].due);
                end
                sb.delete(i);
            end
        end
    end

    function automatic logic [71:0] pat(input int adr);
        logic [5:0] a;
        a = adr[5:0];
        return {12{a}};
    endfunction

    task automatic expect_rd(input int port, input logic [71:0] data, input int lat);
        exp_t e;
        e.due  = cyc + lat;
        e.port = port;
        e.data = data;
        sb.push_back(e);
    endtask

    // One cycle of stimulus; stb is the strobe seen at the coming edge, which is the
    // access edge of the operation driven on the previous call.
    task automatic drive(input bit r0e, input int a0, input bit r1e, input int a1,
                         input bit we, input int wa, input logic [71:0] wd, input bit stb);
        @(negedge clk);
        rd_enb_0 = r0e;  rd_adr_0 = a0[5:0];
        rd_enb_1 = r1e;  rd_adr_1 = a1[5:0];
        wr_enb_0 = we;   wr_adr_0 = wa[5:0];  wr_dat_0 = wd;
        strobe   = stb;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(0, 0, 0, 0, 0, 0, 72'h0, 1);
    endtask

    task automatic wr(input int wa, input logic [71:0] wd);
        drive(0, 0, 0, 0, 1, wa, wd, 1);
    endtask

    localparam logic [71:0] D5   = 72'hA5_0123456789ABCDEF;
    localparam logic [71:0] ONES = 72'hFF_FFFFFFFFFFFFFFFF;

    initial begin
        reset = 1'b0; strobe = 1'b0;
        rd_enb_0 = 0; rd_enb_1 = 0; wr_enb_0 = 0;
        rd_adr_0 = '0; rd_adr_1 = '0; wr_adr_0 = '0; wr_dat_0 = '0;

        // Reset held with random activity: outputs must stay zero.
        for (int k = 0; k < 4; k++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 63), $urandom_range(0, 1),
                  $urandom_range(0, 63), $urandom_range(0, 1), $urandom_range(0, 63),
                  {$urandom, $urandom, $urandom}, $urandom_range(0, 1));
            expect_rd(0, 72'h0, 1);
            expect_rd(1, 72'h0, 1);
        end
        drive(0, 0, 0, 0, 0, 0, 72'h0, 1);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            idle(1);
            expect_rd(0, 72'h0, 2);
            expect_rd(1, 72'h0, 2);
        end

        // Basic write then read with two-clock latency.
        wr(5, D5);
        idle(2);
        drive(1, 5, 0, 0, 0, 0, 72'h0, 1);
        expect_rd(0, D5, 2);
        expect_rd(1, 72'h0, 2);
        idle(2);

        // Dual read of the boundary words.
        wr(0, 72'h0);
        wr(63, ONES);
        idle(1);
        drive(1, 63, 1, 0, 0, 0, 72'h0, 1);
        expect_rd(0, ONES, 2);
        expect_rd(1, 72'h0, 2);
        idle(2);

        // Same address on both ports.
        drive(1, 5, 1, 5, 0, 0, 72'h0, 1);
        expect_rd(0, D5, 2);
        expect_rd(1, D5, 2);
        idle(2);

        // Read/write collision returns old data; the following read sees new data.
        wr(10, 72'h11);
        idle(1);
        drive(1, 10, 0, 0, 1, 10, 72'h22, 1);
        expect_rd(0, 72'h11, 2);
        drive(1, 10, 0, 0, 0, 0, 72'h0, 1);
        expect_rd(0, 72'h22, 2);
        idle(2);

        // Strobe low on the access edge drops both the write and the read.
        wr(3, 72'h33);
        idle(2);
        drive(1, 3, 0, 0, 1, 3, 72'h99, 1);
        expect_rd(0, 72'h22, 2);
        drive(0, 0, 0, 0, 0, 0, 72'h0, 0);
        idle(2);
        drive(1, 3, 0, 0, 0, 0, 72'h0, 1);
        expect_rd(0, 72'h33, 2);
        idle(2);
        // Same operation with strobe high takes effect.
        drive(1, 3, 0, 0, 1, 3, 72'h99, 1);
        expect_rd(0, 72'h33, 2);
        drive(1, 3, 0, 0, 0, 0, 72'h0, 1);
        expect_rd(0, 72'h99, 2);
        idle(2);

        // Sweep writes, interrupted by a reset that swallows a pending overwrite of word 5.
        for (int i = 0; i < 40; i++) wr(i, pat(i));
        idle(2);
        wr(5, 72'hDE_ADBEEFDEADBEEF00);
        @(negedge clk);
        reset = 1'b0;
        wr_enb_0 = 0;
        expect_rd(0, 72'h0, 1);
        expect_rd(1, 72'h0, 1);
        @(negedge clk);
        expect_rd(0, 72'h0, 1);
        expect_rd(1, 72'h0, 1);
        @(negedge clk);
        reset = 1'b1;
        idle(1);
        expect_rd(0, 72'h0, 2);
        expect_rd(1, 72'h0, 2);
        for (int i = 40; i < 64; i++) wr(i, pat(i));
        idle(2);

        // Read back every word on both ports.
        for (int i = 0; i < 64; i++) begin
            drive(1, i, 1, 63 - i, 0, 0, 72'h0, 1);
            expect_rd(0, pat(i), 2);
            expect_rd(1, pat(63 - i), 2);
        end
        idle(4);

        if (sb.size() != 0) begin
            checks += sb.size();
            $display("FAIL scoreboard_drain: got %0d unchecked entries expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
